bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using shift-add-3 (double dabble). It sits directly downstream of the 4x4 array multiplier. It takes the 8-bit product P and produces decimal digits for the hex7seg display drivers, so results show in decimal rather than hex. Conversion uses a start/busy/done handshake and takes one bit per clock.

Parameters:
W, 8, binary input width in bits.
DIGITS, 3, number of BCD output digits; must satisfy 10^DIGITS > 2^W - 1, otherwise elaboration error.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request conversion of bin; sampled only when busy=0.
bin  input  W  unsigned binary value (multiplier product).
busy  output  1  high while a conversion is in progress.
done  output  1  one-cycle pulse when bcd is updated.
bcd  output  4*DIGITS  result; digit i at bits [4i+3:4i]; digit 0 is the units digit.
blank  output  DIGITS  leading-zero blank mask (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, bcd=0, blank=0; internal shift register and counter cleared. Reset mid-conversion aborts it with no done pulse, and bcd reads 0.
- FSM states: IDLE, CONV.
- IDLE, start=1 at edge k:
  - capture bin into shift register; clear BCD scratch register; counter=W.
  - busy=1 from edge k; move to CONV.
- CONV, each edge:
  - every scratch digit >=5 gets +3 (4-bit, no carry out of the digit).
  - then {scratch, shift} shifts left by 1 as one combined register.
  - counter decrements by 1.
  - on the edge where counter reaches 0 (edge k+W): bcd <= final scratch; blank updated; done=1 for exactly one cycle; busy=0; state=IDLE.
- Latency: start accepted at edge k means result and done are valid in the cycle after edge k+W (W+1 edges total including capture).
- start while busy=1 is ignored and not queued. bin is only sampled at the accept edge; later changes do not affect the running conversion.
- start=1 in the done cycle (busy=0) is accepted and begins a new conversion. bcd holds the previous result until the new completion.
- bcd and blank are stable between done pulses. done never asserts without a preceding accepted start.

Optional Feature:
- Macro BIN2BCD_BLANK_EN.
- Defined:
  - blank[i]=1 when digit i and all digits above it are 0, for i>=1.
  - blank[0] is always 0.
  - blank is registered alongside bcd at the done edge.
- Undefined: blank is constant 0 and no blanking logic is synthesized.
- The port is present in both builds.

Decomposition:
- Shared package/include:
  - FSM state encoding (IDLE=1'b0, CONV=1'b1).
  - BCD_ADJ_THRESH=4'd5 and BCD_ADJ_ADD=4'd3.
  - counter width constant $clog2(W+1).
- One natural combinational sub-module, bcd_digit_adj: 4-bit in, 4-bit out, output = in + 3 if in >= 5. Instantiated DIGITS times in a generate loop.
- FSM, counter and registers stay in bin2bcd_seq.

Test Plan:
- bin=8'd225 (15x15), start 1 cycle: busy for 8 cycles; done pulse at edge 8; bcd=12'h225, blank=3'b000.
- bin=8'd0: bcd=12'h000. With BIN2BCD_BLANK_EN, blank=3'b110; without it, blank=3'b000.
- bin=8'd255, then bin=8'd9 with start held in the done cycle: first bcd=12'h255, then bcd=12'h009 eight edges later; blank=3'b110 under the macro.
- start re-pulsed with bin=8'd1 mid-conversion of 8'd100: ignored; single done; bcd=12'h100.
- rst_n low at cycle 4 of converting 8'd77: busy=0, bcd=0 immediately; no done. After release, a start with 8'd77 yields 12'h077.
- Exhaustive sweep bin=0..255: bcd decodes back to bin in every case; busy high exactly 8 cycles each time.

Source files
------------

// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the FSM encoding, the digit adjust constants and the counter width helper.
package bin2bcd_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    // The bit counter must hold the value W itself, so it needs $clog2(W+1) bits.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_adj.sv
// Single BCD digit pre-shift correction for double dabble: add 3 when the digit is 5 or more.
// The result wraps within 4 bits, so no carry leaves the digit.
module bcd_digit_adj
    import bin2bcd_seq_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= BCD_ADJ_THRESH) ? din + BCD_ADJ_ADD : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per clock, start/busy/done handshake.
// Optional leading-zero blank mask is enabled with the BIN2BCD_BLANK_EN macro.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int W      = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [W-1:0]          bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank
);

    localparam int CW = cnt_width(W);
    localparam int BW = 4 * DIGITS;

    if (pow10(DIGITS) <= ((64'd1 << W) - 64'd1)) begin : g_digits_too_few
        $error("bin2bcd_seq: DIGITS too small to represent 2^W-1");
    end

    state_t          state;
    logic [BW-1:0]   scratch;
    logic [BW-1:0]   scr_adj;
    logic [BW-1:0]   scr_next;
    logic [W-1:0]    shreg;
    logic [CW-1:0]   cnt;
    logic            last;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scratch[4*g +: 4]),
            .dout (scr_adj[4*g +: 4])
        );
    end

    // Adjusted scratch and the binary shift register shift left as one combined register.
    assign scr_next = {scr_adj[BW-2:0], shreg[W-1]};
    assign last     = (state == CONV) && (cnt == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
            scratch <= '0;
            shreg   <= '0;
            cnt     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= bin;
                        scratch <= '0;
                        cnt     <= CW'(W);
                        busy    <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    scratch <= scr_next;
                    shreg   <= shreg << 1;
                    cnt     <= cnt - CW'(1);
                    if (last) begin
                        bcd   <= scr_next;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank_next;
    logic              zero_run;

    // A digit blanks only when it and every digit above it are zero; units never blank.
    always_comb begin
        blank_next = '0;
        zero_run   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run      = zero_run && (scr_next[4*i +: 4] == 4'd0);
            blank_next[i] = zero_run;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    blank <= '0;
        else if (last) blank <= blank_next;
    end
`else
    assign blank = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq (W=8, DIGITS=3).
// Expected blank mask follows BIN2BCD_BLANK_EN when the bench is compiled with it.
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  bin;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
    logic [2:0]  blank;

    int tests = 0;
    int fails = 0;

    bin2bcd_seq #(.W(8), .DIGITS(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .blank (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [2:0] exp_blank(input int v);
`ifdef BIN2BCD_BLANK_EN
        if (v == 0)       return 3'b110;
        else if (v < 10)  return 3'b110;
        else if (v < 100) return 3'b100;
        else              return 3'b000;
`else
        return (v < 0) ? 3'b111 : 3'b000;
`endif
    endfunction

    // Pulse start for one clock, driven on the falling edge.
    task automatic pulse_start(input logic [7:0] b);
        start = 1'b1;
        bin   = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count busy cycles until done is seen on a falling edge; bounded.
    task automatic wait_done(output int nbusy, output bit got);
        nbusy = 0;
        got   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) nbusy++;
            @(negedge clk);
        end
    endtask

    int  nb;
    bit  got;
    int  ndone;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        bin   = '0;
        #12;
        check("reset_busy",  32'(busy),  32'd0);
        check("reset_done",  32'(done),  32'd0);
        check("reset_bcd",   32'(bcd),   32'd0);
        check("reset_blank", 32'(blank), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 15x15 = 225
        pulse_start(8'd225);
        wait_done(nb, got);
        check("225_got_done", 32'(got), 32'd1);
        check("225_busy_cycles", 32'(nb), 32'd8);
        check("225_bcd", 32'(bcd), 32'h225);
        check("225_blank", 32'(blank), 32'(exp_blank(225)));
        @(negedge clk);
        check("225_done_one_cycle", 32'(done), 32'd0);
        check("225_bcd_hold", 32'(bcd), 32'h225);

        // zero
        pulse_start(8'd0);
        wait_done(nb, got);
        check("0_got_done", 32'(got), 32'd1);
        check("0_bcd", 32'(bcd), 32'h000);
        check("0_blank", 32'(blank), 32'(exp_blank(0)));
        @(negedge clk);

        // 255 then 9 with start held in the done cycle
        pulse_start(8'd255);
        wait_done(nb, got);
        check("255_got_done", 32'(got), 32'd1);
        check("255_bcd", 32'(bcd), 32'h255);
        check("255_blank", 32'(blank), 32'(exp_blank(255)));
        check("255_busy_low_in_done", 32'(busy), 32'd0);
        pulse_start(8'd9);
        check("9_busy_after_accept", 32'(busy), 32'd1);
        check("9_bcd_holds_prev", 32'(bcd), 32'h255);
        wait_done(nb, got);
        check("9_got_done", 32'(got), 32'd1);
        check("9_busy_cycles", 32'(nb), 32'd8);
        check("9_bcd", 32'(bcd), 32'h009);
        check("9_blank", 32'(blank), 32'(exp_blank(9)));
        @(negedge clk);

        // start re-pulsed mid-conversion is ignored
        pulse_start(8'd100);
        @(negedge clk);
        @(negedge clk);
        pulse_start(8'd1);
        bin   = 8'd1;
        ndone = 0;
        for (int i = 0; i < 16; i++) begin
            if (done) ndone++;
            if (done) check("100_bcd_at_done", 32'(bcd), 32'h100);
            @(negedge clk);
        end
        check("100_single_done", 32'(ndone), 32'd1);
        check("100_bcd_final", 32'(bcd), 32'h100);
        check("100_idle", 32'(busy), 32'd0);

        // reset mid-conversion of 77
        pulse_start(8'd77);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_bcd",  32'(bcd),  32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) ndone++;
            if (i == 3) rst_n = 1'b1;
        end
        check("rst_mid_no_done", 32'(ndone), 32'd0);
        check("rst_mid_bcd_after", 32'(bcd), 32'd0);
        pulse_start(8'd77);
        wait_done(nb, got);
        check("77_got_done", 32'(got), 32'd1);
        check("77_bcd", 32'(bcd), 32'h077);
        check("77_blank", 32'(blank), 32'(exp_blank(77)));
        @(negedge clk);

        // exhaustive sweep
        for (int v = 0; v < 256; v++) begin
            pulse_start(8'(v));
            bin = 8'(255 - v);
            wait_done(nb, got);
            check($sformatf("sweep_%0d_done", v), 32'(got), 32'd1);
            check($sformatf("sweep_%0d_busy", v), 32'(nb), 32'd8);
            check($sformatf("sweep_%0d_bcd", v), 32'(bcd), 32'(to_bcd(v)));
            check($sformatf("sweep_%0d_blank", v), 32'(blank), 32'(exp_blank(v)));
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
